dm_wait_responder: RTL

//  Data-memory responder: the slave end of the controller's DM_enable/DM_read/DM_write interface.

---
 rtl/dm_wait_responder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dm_wait_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_wait_responder
// Brief    : Word-addressed data memory with programmable read/write wait
//            states, CPU stall handshake and rejected-access error pulse.
// Revision : 1.0 - initial release
// ============================================================================
module dm_wait_responder #(
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DM_enable,
    input  logic        DM_read,
    input  logic        DM_write,
    input  logic [31:0] DM_address,
    input  logic [31:0] DM_in,
    output logic [31:0] DM_out,
    output logic        CPU_STALL,
    output logic        DM_err
);

    localparam int         c_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_RD_LAT = 4'(RD_LAT);
    localparam logic [3:0] c_WR_LAT = 4'(WR_LAT);
    localparam logic [3:0] c_RW_LAT = (RD_LAT > WR_LAT) ? c_RD_LAT : c_WR_LAT;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (RD_LAT < 0 || RD_LAT > 15 || WR_LAT < 0 || WR_LAT > 15) begin : g_lat_check
            $error("dm_wait_responder: RD_LAT/WR_LAT must be within 0..15");
        end
    endgenerate

    logic [1:0]      r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic [c_AW-1:0] r_idx;
    logic [31:0]     r_data;
    logic            r_write;
    logic            r_bad;
    logic [31:0]     r_mem [DEPTH];

    logic            w_both, w_req, w_accept, w_in_bad;
    logic [3:0]      w_in_lat;
    logic            w_latch, w_commit, w_c_write, w_c_bad;
    logic [c_AW-1:0] w_c_idx;
    logic [31:0]     w_c_data;
    logic            w_we, w_re;

    always_comb begin
        w_both   = DM_enable & DM_read & DM_write;
        w_req    = DM_enable & (DM_read ^ DM_write);
        w_accept = w_req | w_both;
        w_in_lat = w_both ? c_RW_LAT : (DM_read ? c_RD_LAT : c_WR_LAT);
        w_in_bad = w_both | (DM_address[1:0] != 2'b00)
                 | ({2'b00, DM_address[31:2]} >= 32'(DEPTH));
    end

    // A zero-latency access commits straight from the live inputs; otherwise
    // the commit uses the values captured on the request edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        CPU_STALL   = 1'b0;
        w_latch     = 1'b0;
        w_commit    = 1'b0;
        w_c_write   = r_write;
        w_c_bad     = r_bad;
        w_c_idx     = r_idx;
        w_c_data    = r_data;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_in_lat != 4'd0) begin
                        CPU_STALL   = 1'b1;
                        w_latch     = 1'b1;
                        w_cnt_nxt   = w_in_lat - 4'd1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_commit    = 1'b1;
                        w_c_write   = DM_write;
                        w_c_bad     = w_in_bad;
                        w_c_idx     = DM_address[c_AW+1:2];
                        w_c_data    = DM_in;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt != 4'd0) begin
                    CPU_STALL = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        DM_err = w_commit & w_c_bad;
        w_we   = w_commit & w_c_write & ~w_c_bad & ~rst;
        w_re   = w_commit & ~w_c_write & ~w_c_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_data  <= 32'd0;
            r_write <= 1'b0;
            r_bad   <= 1'b0;
            DM_out  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_idx   <= DM_address[c_AW+1:2];
                r_data  <= DM_in;
                r_write <= DM_write;
                r_bad   <= w_in_bad;
            end
            if (w_re) begin
                DM_out <= r_mem[w_c_idx];
            end
        end
    end

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_c_idx] <= w_c_data;
        end
    end

endmodule
`default_nettype wire
